pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 64, payload width in bits (≥1).
REQ-002 Parameter SKID, default 1; 1 = two-entry elastic stage with registered in_ready, 0 = single-entry stage.
REQ-003 Parameter CLEAR_DATA, default 1; 1 = payload registers zeroed on reset/flush, 0 = payload registers hold their value.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  synchronous squash of stage contents (branch/hazard kill).
REQ-007 in_valid  input  1  upstream payload valid.
REQ-008 in_ready  output  1  stage can accept a payload this cycle.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  out_data holds a live payload.
REQ-011 out_ready  input  1  downstream accepts a payload this cycle.
REQ-012 out_data  output  WIDTH  payload at the head of the stage.
REQ-013 occupancy  output  2  number of held payloads (0..2).
REQ-014 stall_cycles  output  16  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-015 Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-016 States: EMPTY (occupancy 0), ONE (main register full, occupancy 1), TWO (main and skid registers full, occupancy 2); TWO is reachable only when SKID=1.
REQ-017 out_valid = (state != EMPTY); out_data = main register, driven directly from flops.
REQ-018 SKID=1: in_ready = (state != TWO), derived from state flops only, with no combinational path from out_ready.
REQ-019 SKID=0: in_ready = !out_valid | out_ready (combinational pass-through of out_ready).
REQ-020 EMPTY: in_fire -> main<=in_data, go to ONE; otherwise stay.
REQ-021 ONE with in_fire & out_fire -> main<=in_data, stay in ONE.
REQ-022 ONE with in_fire only -> skid<=in_data, go to TWO (SKID=1).
REQ-023 ONE with out_fire only -> go to EMPTY.
REQ-024 TWO: out_fire -> main<=skid, go to ONE; otherwise hold.
REQ-025 Latency: a payload accepted at edge N is visible on out_data after edge N; payloads exit in strict acceptance order, with no loss and no duplication.
REQ-026 Throughput: one transfer per cycle sustained while out_ready=1.
REQ-027 Flush: at the next edge state<=EMPTY, and main and skid are zeroed if CLEAR_DATA=1.
REQ-028 Flush: any in_fire in the flush cycle is counted as consumed by upstream and is discarded.
REQ-029 Flush: an out_fire in the flush cycle completes normally downstream.
REQ-030 Flush with out_valid=1 and out_ready=0: the payload is dropped; the stall cycle is still counted.
REQ-031 stall_cycles increments by 1 per stall cycle, saturates at 16'hFFFF, and is unaffected by flush.
REQ-032 When in_valid=0 and out_ready=0, all registers hold their values.

Reset
REQ-033 reset has priority over flush and over all handshakes.
REQ-034 Reset state: EMPTY, out_valid=0, occupancy=0, stall_cycles=0.
REQ-035 Reset: in_ready=1 from the first cycle after reset.
REQ-036 Reset: out_data=0 when CLEAR_DATA=1.
REQ-037 Reset asserted mid-transfer discards all held payloads, with no partial update.

Structure
REQ-038 Package pipe_pkg holds the state enum (EMPTY/ONE/TWO) and the STALL_CNT_W=16 constant.
REQ-039 Sub-module sat_counter (parameter width, inputs inc and clr, saturating) implements stall_cycles.
REQ-040 Stage-specific struct payloads are packed into in_data/out_data by the instantiating pipeline, not by this block.

Verification
REQ-041 SKID=1, out_ready=0, in_data 0xA, then 0xB -> occupancy 2, in_ready=0; third payload 0xC held off; release out_ready -> outputs 0xA, 0xB, 0xC in order.
REQ-042 Stream of 100 payloads with out_ready=1 -> 100 outputs on 100 consecutive cycles, in_ready constantly 1.
REQ-043 State TWO (0x1, 0x2) plus flush with in_valid=1 carrying 0x3 -> next cycle out_valid=0, out_data=0, occupancy 0; 0x3 never emitted.
REQ-044 SKID=0, out_ready toggling 1/0 -> in_ready equals !out_valid | out_ready each cycle, and no payload is lost.
REQ-045 out_valid=1 with out_ready=0 held for 70000 cycles -> stall_cycles=0xFFFF; reset -> 0.
REQ-046 reset and flush asserted together in state ONE -> EMPTY, stall_cycles=0, in_ready=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage register.
// The stage state encoding equals the number of payloads held.
package pipe_pkg;

   localparam int STALL_CNT_W = 16;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } stage_state_e;

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// Up-counter that sticks at its maximum value.
// clr wins over inc.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (inc && (count != {WIDTH{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule : sat_counter

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage: one-entry, or two-entry skid buffer with a
// registered in_ready, plus flush and a saturating stall-cycle counter.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int WIDTH      = 64,
   parameter int SKID       = 1,
   parameter int CLEAR_DATA = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic [1:0]             occupancy,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   localparam logic USE_SKID  = (SKID != 0);
   localparam logic CLR_DATA  = (CLEAR_DATA != 0);

   stage_state_e     state_q, state_d;
   logic [WIDTH-1:0] main_p1, skid_p1;
   logic             in_fire, out_fire;
   logic             load_main, load_skid, main_from_skid;

   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_p1;
   assign occupancy = state_q;

   // With the skid entry in_ready depends only on flops, breaking the ready chain.
   assign in_ready  = USE_SKID ? (state_q != TWO) : (!out_valid || out_ready);

   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

   always_comb begin
      state_d        = state_q;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      case (state_q)
         EMPTY: begin
            if (in_fire) begin
               load_main = 1'b1;
               state_d   = ONE;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               load_main = 1'b1;
            end else if (in_fire && USE_SKID) begin
               load_skid = 1'b1;
               state_d   = TWO;
            end else if (out_fire) begin
               state_d   = EMPTY;
            end
         end
         TWO: begin
            if (out_fire) begin
               main_from_skid = 1'b1;
               state_d        = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      // A flush kills whatever is held or arriving; an out_fire still completes.
      if (flush) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Payload registers: cleared on reset/flush only when CLEAR_DATA is set.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         if (CLR_DATA) begin
            main_p1 <= '0;
            skid_p1 <= '0;
         end
      end else begin
         if (load_main) begin
            main_p1 <= in_data;
         end else if (main_from_skid) begin
            main_p1 <= skid_p1;
         end
         if (load_skid) begin
            skid_p1 <= in_data;
         end
      end
   end

   sat_counter #(
      .WIDTH(STALL_CNT_W)
   ) u_stall_cnt (
      .clk  (clk),
      .clr  (reset),
      .inc  (out_valid && !out_ready),
      .count(stall_cycles)
   );

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a skid instance (SKID=1) and a
// single-entry instance (SKID=0), both with CLEAR_DATA=1.
module tb_pipe_stage_reg;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          mon_en = 1'b0;
   int            checks = 0;
   int            errors = 0;

   logic          a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
   logic [W-1:0]  a_in_data = '0;
   logic          a_in_ready, a_out_valid;
   logic [W-1:0]  a_out_data;
   logic [1:0]    a_occupancy;
   logic [15:0]   a_stall_cycles;

   logic          b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
   logic [W-1:0]  b_in_data = '0;
   logic          b_in_ready, b_out_valid;
   logic [W-1:0]  b_out_data;
   logic [1:0]    b_occupancy;
   logic [15:0]   b_stall_cycles;
   logic          b_tog_en = 1'b0;

   logic [W-1:0]  aq[$];
   logic [W-1:0]  bq[$];
   logic [15:0]   a_exp_stall = '0;
   int            a_pops = 0;
   int            b_pops = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.WIDTH(W), .SKID(1), .CLEAR_DATA(1)) u_dut_a (
      .clk(clk), .reset(reset), .flush(a_flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .occupancy(a_occupancy), .stall_cycles(a_stall_cycles)
   );

   pipe_stage_reg #(.WIDTH(W), .SKID(0), .CLEAR_DATA(1)) u_dut_b (
      .clk(clk), .reset(reset), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .occupancy(b_occupancy), .stall_cycles(b_stall_cycles)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: compare current outputs with the model, then advance the
   // model by what will happen at the coming rising edge.
   always @(negedge clk) begin
      if (mon_en) begin
         check("a_occ", a_occupancy, aq.size());
         check("a_vld", a_out_valid, aq.size() != 0);
         check("a_rdy", a_in_ready, aq.size() < 2);
         check("a_stall", a_stall_cycles, a_exp_stall);
         if (a_out_valid && a_out_ready) begin
            check("a_sb_nonempty", aq.size() != 0, 1);
            if (aq.size() != 0) begin
               check("a_data", a_out_data, aq.pop_front());
               a_pops++;
            end
         end
         if (reset) begin
            aq.delete();
            a_exp_stall = '0;
         end else begin
            if (a_out_valid && !a_out_ready && a_exp_stall != 16'hFFFF) a_exp_stall++;
            if (a_flush) aq.delete();
            else if (a_in_valid && a_in_ready) aq.push_back(a_in_data);
         end

         check("b_occ", b_occupancy, bq.size());
         check("b_vld", b_out_valid, bq.size() != 0);
         check("b_rdy", b_in_ready, (bq.size() == 0) || b_out_ready);
         if (b_out_valid && b_out_ready) begin
            check("b_sb_nonempty", bq.size() != 0, 1);
            if (bq.size() != 0) begin
               check("b_data", b_out_data, bq.pop_front());
               b_pops++;
            end
         end
         if (reset || b_flush) bq.delete();
         else if (b_in_valid && b_in_ready) bq.push_back(b_in_data);
      end
   end

   always @(posedge clk) begin
      if (b_tog_en) begin
         #1;
         b_out_ready = ~b_out_ready;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic accept_a();
      int n = 0;
      @(negedge clk);
      while (!a_in_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("a_accept_timeout", n < 1000, 1);
      cyc();
      a_in_valid = 1'b0;
   endtask

   task automatic send_a(input logic [W-1:0] d);
      a_in_valid = 1'b1;
      a_in_data  = d;
      accept_a();
   endtask

   task automatic send_b(input logic [W-1:0] d);
      int n = 0;
      b_in_valid = 1'b1;
      b_in_data  = d;
      @(negedge clk);
      while (!b_in_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("b_accept_timeout", n < 1000, 1);
      cyc();
      b_in_valid = 1'b0;
   endtask

   task automatic drain_a();
      int n = 0;
      while (aq.size() != 0 && n < 200) begin
         cyc();
         n++;
      end
      cyc();
      check("a_drain", aq.size(), 0);
   endtask

   initial begin
      int p0;
      repeat (2) cyc();
      reset = 1'b0;
      @(negedge clk);
      check("rst_vld", a_out_valid, 0);
      check("rst_occ", a_occupancy, 0);
      check("rst_stall", a_stall_cycles, 0);
      check("rst_rdy", a_in_ready, 1);
      check("rst_data", a_out_data, 0);
      check("rst_b_rdy", b_in_ready, 1);
      mon_en = 1'b1;
      cyc();

      // Fill both entries, hold off a third, then release in order.
      a_out_ready = 1'b0;
      send_a(16'h000A);
      send_a(16'h000B);
      a_in_valid = 1'b1;
      a_in_data  = 16'h000C;
      repeat (3) cyc();
      @(negedge clk);
      check("full_occ", a_occupancy, 2);
      check("full_rdy", a_in_ready, 0);
      cyc();
      p0 = a_pops;
      a_out_ready = 1'b1;
      accept_a();
      drain_a();
      check("full_pops", a_pops - p0, 3);

      // Sustained streaming with out_ready held high.
      p0 = a_pops;
      for (int i = 0; i < 100; i++) begin
         a_in_valid = 1'b1;
         a_in_data  = 16'h1000 + i[15:0];
         @(negedge clk);
         check("stream_rdy", a_in_ready, 1);
         cyc();
      end
      a_in_valid = 1'b0;
      cyc();
      check("stream_pops", a_pops - p0, 100);

      // Flush in TWO with an incoming payload that must vanish.
      a_out_ready = 1'b0;
      send_a(16'h0001);
      send_a(16'h0002);
      a_in_valid = 1'b1;
      a_in_data  = 16'h0003;
      a_flush    = 1'b1;
      cyc();
      a_flush    = 1'b0;
      a_in_valid = 1'b0;
      @(negedge clk);
      check("flush_vld", a_out_valid, 0);
      check("flush_data", a_out_data, 0);
      check("flush_occ", a_occupancy, 0);
      cyc();
      p0 = a_pops;
      a_out_ready = 1'b1;
      repeat (3) cyc();
      check("flush_no_emit", a_pops - p0, 0);

      // Flush in ONE: accepted input discarded; a concurrent out_fire completes.
      a_out_ready = 1'b0;
      send_a(16'h0005);
      a_in_valid = 1'b1;
      a_in_data  = 16'h0006;
      a_flush    = 1'b1;
      cyc();
      a_flush    = 1'b0;
      a_in_valid = 1'b0;
      @(negedge clk);
      check("flush1_occ", a_occupancy, 0);
      cyc();
      send_a(16'h0007);
      p0 = a_pops;
      a_out_ready = 1'b1;
      a_flush     = 1'b1;
      cyc();
      a_flush     = 1'b0;
      cyc();
      check("flush_outfire", a_pops - p0, 1);

      // Single-entry stage with out_ready toggling every cycle.
      p0 = b_pops;
      b_tog_en = 1'b1;
      for (int i = 0; i < 20; i++) send_b(16'h0100 + i[15:0]);
      repeat (6) cyc();
      b_tog_en = 1'b0;
      cyc();
      b_out_ready = 1'b1;
      repeat (3) cyc();
      check("b_pops", b_pops - p0, 20);
      check("b_empty", bq.size(), 0);

      // Long stall saturates the counter; then reset together with flush.
      a_out_ready = 1'b0;
      send_a(16'h0009);
      repeat (65600) cyc();
      @(negedge clk);
      check("stall_sat", a_stall_cycles, 16'hFFFF);
      cyc();
      reset   = 1'b1;
      a_flush = 1'b1;
      cyc();
      reset   = 1'b0;
      a_flush = 1'b0;
      @(negedge clk);
      check("rf_vld", a_out_valid, 0);
      check("rf_occ", a_occupancy, 0);
      check("rf_stall", a_stall_cycles, 0);
      check("rf_rdy", a_in_ready, 1);
      check("rf_data", a_out_data, 0);
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_pipe_stage_reg
